piso_tx: RTL and testbench

Parallel-in/serial-out framed transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on a single line: one start bit, then the data LSB first, then one stop bit. Each bit is held for DIV clocks. It is built from the same edge-triggered flop primitives as the rest of the library, and it is the transmitting end for the team's serial-in/parallel-out receiver.

---
 rtl/piso_tx_if.sv | 13 +
 rtl/piso_tx.sv | 92 +++++++++
 tb/tb_piso_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Word-in handshake and serial-line bundle between a word source and piso_tx.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             load;
    logic             ready;
    logic             so;
    logic             busy;

    modport master (output d, load, input ready, so, busy);
    modport slave  (input d, load, output ready, so, busy);
endinterface

// File: rtl/piso_tx.sv
// Framed PISO transmitter: start bit, WIDTH data bits LSB first, stop bit; each bit held DIV clocks.
// The accepting edge starts the start bit; ready stays low for (WIDTH+2)*DIV clocks; load while busy is dropped.
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic ck,
    input  logic rn,
    piso_tx_if.slave bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt, div_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             div_last;

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        div_last  = (div_cnt == DIV_LAST);
        case (state)
            IDLE: begin
                if (bus.load) begin
                    state_nxt = START;
                    shreg_nxt = bus.d;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (div_last) begin
                    state_nxt = DATA;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_nxt   = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            STOP: begin
                if (div_last) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only flops, so reset forces the idle line level without a clock.
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.so    = (state == START) ? 1'b0 :
                       (state == DATA)  ? shreg[0] : 1'b1;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a DIV=4 and a DIV=1 instance checked against a frame-level line model.
module tb_piso_tx;
    logic ck = 1'b0;
    logic rn = 1'b0;
    bit   clk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    piso_tx_if #(.WIDTH(8)) if0 ();
    piso_tx_if #(.WIDTH(8)) if1 ();

    piso_tx #(.WIDTH(8), .DIV(4)) u_dut0 (.ck(ck), .rn(rn), .bus(if0.slave));
    piso_tx #(.WIDTH(8), .DIV(1)) u_dut1 (.ck(ck), .rn(rn), .bus(if1.slave));

    always begin
        #5;
        if (clk_en) ck = ~ck;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic obs_so [0:127];
    logic obs_rdy[0:127];
    logic obs_bsy[0:127];
    logic exp_so [0:127];
    logic exp_rdy[0:127];

    // Line level at clock k of a frame: start(0), data LSB first, stop(1), each div clocks wide.
    function automatic logic frame_bit(input logic [7:0] data, input int div, input int k);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        return frame[k / div];
    endfunction

    // Expected trace after an accepting edge: frame a, then (if two) one idle clock and frame b.
    task automatic build_expect(input int div, input logic [7:0] a, input logic [7:0] b,
                                input bit two, input int n);
        int len;
        len = 10 * div;
        for (int k = 0; k < n; k++) begin
            if (k < len) begin
                exp_so[k] = frame_bit(a, div, k); exp_rdy[k] = 1'b0;
            end else if (two && k > len && (k - len - 1) < len) begin
                exp_so[k] = frame_bit(b, div, k - len - 1); exp_rdy[k] = 1'b0;
            end else begin
                exp_so[k] = 1'b1; exp_rdy[k] = 1'b1;
            end
        end
    endtask

    task automatic start_load(input int which, input logic [7:0] data);
        @(negedge ck);
        if (which == 1) begin if1.d = data; if1.load = 1'b1; end
        else            begin if0.d = data; if0.load = 1'b1; end
    endtask

    // Records n samples on falling edges after the next rising edge; drives load/d per sample index.
    task automatic capture(input int which, input int n, input int hold_until, input int pulse_at,
                           input int newd_at, input logic [7:0] newd);
        logic ld;
        @(posedge ck);
        for (int k = 0; k < n; k++) begin
            @(negedge ck);
            obs_so[k]  = (which == 1) ? if1.so    : if0.so;
            obs_rdy[k] = (which == 1) ? if1.ready : if0.ready;
            obs_bsy[k] = (which == 1) ? if1.busy  : if0.busy;
            ld = (k < hold_until) || (k == pulse_at);
            if (which == 1) begin if1.load = ld; if (k == newd_at) if1.d = newd; end
            else            begin if0.load = ld; if (k == newd_at) if0.d = newd; end
        end
        if0.load = 1'b0;
        if1.load = 1'b0;
    endtask

    task automatic test_reset;
        if0.load = 1'b0; if0.d = '0;
        if1.load = 1'b0; if1.d = '0;
        #20;
        checks++; if (if0.so !== 1'b1)    begin errors++; $display("FAIL reset so: got %b expected 1", if0.so); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b expected 1", if0.ready); end
        checks++; if (if0.busy !== 1'b0)  begin errors++; $display("FAIL reset busy: got %b expected 0", if0.busy); end
        checks++; if (if1.ready !== 1'b1) begin errors++; $display("FAIL reset ready div1: got %b expected 1", if1.ready); end
        clk_en = 1'b1;
        @(negedge ck);
        rn = 1'b1;
        repeat (2) @(negedge ck);
    endtask

    task automatic test_single;
        start_load(0, 8'hA5);
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL single pre-ready: got %b expected 1", if0.ready); end
        capture(0, 44, 0, -1, -1, 8'h00);
        build_expect(4, 8'hA5, 8'h00, 1'b0, 44);
        for (int k = 0; k < 44; k++) begin
            checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL single so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
            checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL single ready[%0d]: got %b expected %b", k, obs_rdy[k], exp_rdy[k]); end
            checks++; if (obs_bsy[k] !== ~exp_rdy[k]) begin errors++; $display("FAIL single busy[%0d]: got %b expected %b", k, obs_bsy[k], ~exp_rdy[k]); end
        end
    endtask

    task automatic test_ignored_load;
        start_load(0, 8'hFF);
        capture(0, 48, 0, 9, 9, 8'h00);
        build_expect(4, 8'hFF, 8'h00, 1'b0, 48);
        for (int k = 0; k < 48; k++) begin
            checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL ignored so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
            checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL ignored ready[%0d]: got %b expected %b", k, obs_rdy[k], exp_rdy[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        start_load(0, 8'h3C);
        capture(0, 84, 41, -1, 20, 8'hC3);
        build_expect(4, 8'h3C, 8'hC3, 1'b1, 84);
        for (int k = 0; k < 84; k++) begin
            checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL b2b so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
            checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL b2b ready[%0d]: got %b expected %b", k, obs_rdy[k], exp_rdy[k]); end
        end
        gap = 0;
        for (int k = 9 * 4; k < 84 && obs_so[k] === 1'b1; k++) gap++;
        checks++; if (gap != 4 + 1) begin errors++; $display("FAIL b2b gap: got %0d clocks high expected %0d", gap, 4 + 1); end
    endtask

    task automatic test_midframe_reset;
        start_load(0, 8'h55);
        capture(0, 18, 0, -1, -1, 8'h00);
        build_expect(4, 8'h55, 8'h00, 1'b0, 18);
        for (int k = 0; k < 18; k++) begin
            checks++; if (obs_so[k] !== exp_so[k]) begin errors++; $display("FAIL midrst pre so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
        end
        #1 rn = 1'b0;
        #1;
        checks++; if (if0.so !== 1'b1)    begin errors++; $display("FAIL midrst so: got %b expected 1", if0.so); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL midrst ready: got %b expected 1", if0.ready); end
        checks++; if (if0.busy !== 1'b0)  begin errors++; $display("FAIL midrst busy: got %b expected 0", if0.busy); end
        if0.d = 8'hEE; if0.load = 1'b1;
        @(posedge ck);
        @(negedge ck);
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL midrst load-in-reset ready: got %b expected 1", if0.ready); end
        checks++; if (if0.so !== 1'b1)    begin errors++; $display("FAIL midrst load-in-reset so: got %b expected 1", if0.so); end
        if0.load = 1'b0;
        rn = 1'b1;
        @(negedge ck);
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL midrst post ready: got %b expected 1", if0.ready); end
        start_load(0, 8'h81);
        capture(0, 43, 0, -1, -1, 8'h00);
        build_expect(4, 8'h81, 8'h00, 1'b0, 43);
        for (int k = 0; k < 43; k++) begin
            checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL midrst frame so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
            checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL midrst frame ready[%0d]: got %b expected %b", k, obs_rdy[k], exp_rdy[k]); end
        end
    endtask

    task automatic test_div1;
        start_load(1, 8'h01);
        capture(1, 13, 0, -1, -1, 8'h00);
        build_expect(1, 8'h01, 8'h00, 1'b0, 13);
        for (int k = 0; k < 13; k++) begin
            checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL div1 so[%0d]: got %b expected %b", k, obs_so[k], exp_so[k]); end
            checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL div1 ready[%0d]: got %b expected %b", k, obs_rdy[k], exp_rdy[k]); end
        end
    endtask

    task automatic test_random;
        int which, div, n;
        logic [7:0] data;
        for (int i = 0; i < 10; i++) begin
            which = $urandom_range(0, 1);
            div   = (which == 1) ? 1 : 4;
            n     = 10 * div + 2;
            data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge ck);
            start_load(which, data);
            capture(which, n, 0, -1, 3, 8'($urandom));
            build_expect(div, data, 8'h00, 1'b0, n);
            for (int k = 0; k < n; k++) begin
                checks++; if (obs_so[k] !== exp_so[k])   begin errors++; $display("FAIL random %0d d=%h so[%0d]: got %b expected %b", i, data, k, obs_so[k], exp_so[k]); end
                checks++; if (obs_rdy[k] !== exp_rdy[k]) begin errors++; $display("FAIL random %0d d=%h ready[%0d]: got %b expected %b", i, data, k, obs_rdy[k], exp_rdy[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignored_load();
        test_back_to_back();
        test_midframe_reset();
        test_div1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
